// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
//
// Instruction-fetch control stage placed directly after the PC register.
// Issues the current PC to instruction memory over a req/ack handshake,
// captures the returned word into the IF/ID register, and tells the PC
// register when to advance (o_pcend = 0 loads npc). Handles decode
// back-pressure and branch/exception flushes, including draining a fetch
// that was already in flight when a flush arrived.
//
// Optional feature macro: IFETCH_ALIGN_CHECK_EN
//   defined   : a misaligned PC (pc[1:0] != 0) is not sent to memory. It is
//               retired immediately as a nop carrying o_if_exc = 1.
//   undefined : pc[1:0] is ignored and o_if_exc is constant 0.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous reset, active low
//   i_pc           current PC from the PC register
//   o_pcend        1 = PC register holds, 0 = PC register loads npc
//   o_imem_req     fetch request
//   o_imem_addr    word-aligned fetch address
//   i_imem_ack     fetch data valid (may arrive in the request cycle)
//   i_imem_rdata   fetched word, qualified by i_imem_ack
//   i_id_stall     decode cannot take a new instruction
//   i_flush        redirect; PC register loads the target this cycle
//   o_if_valid     IF/ID holds a valid instruction
//   o_if_instr     IF/ID instruction
//   o_if_pc        address of o_if_instr
//   o_if_pc4       o_if_pc + 4
//   o_if_exc       fetch exception flag
//   o_fetch_cnt    instructions accepted into IF/ID, wraps at 2^32
// ----------------------------------------------------------------------------
module ifetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_pcend,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    input  logic              i_id_stall,
    input  logic              i_flush,
    output logic              o_if_valid,
    output logic [DATA_W-1:0] o_if_instr,
    output logic [ADDR_W-1:0] o_if_pc,
    output logic [ADDR_W-1:0] o_if_pc4,
    output logic              o_if_exc,
    output logic [31:0]       o_fetch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_drop_addr;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_if_instr;
    logic [ADDR_W-1:0] r_if_pc;
    logic [ADDR_W-1:0] r_if_pc4;
    logic              r_if_exc;
    logic [31:0]       r_fetch_cnt;

    logic [ADDR_W-1:0] w_pc_aligned;
    logic              w_misaligned;
    logic              w_slot_free;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              w_pcend;
    logic              w_accept;      // normal fetch captured into IF/ID
    logic              w_exc_accept;  // misaligned PC retired as nop + exception
    logic              w_drop_load;   // flush caught a fetch in flight

    assign w_pc_aligned = {i_pc[ADDR_W-1:2], 2'b00};

`ifdef IFETCH_ALIGN_CHECK_EN
    assign w_misaligned = (i_pc[1:0] != 2'b00);
`else
    // Low PC bits are deliberately dropped; keep them visibly consumed.
    logic w_unused_pc_lsb;
    assign w_unused_pc_lsb = ^i_pc[1:0];
    assign w_misaligned    = 1'b0;
`endif

    // A new word may enter IF/ID if it is empty or decode is draining it.
    assign w_slot_free = !r_if_valid || !i_id_stall;

    // ------------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        w_next       = r_state;
        w_req        = 1'b0;
        w_addr       = w_pc_aligned;
        w_pcend      = 1'b1;
        w_accept     = 1'b0;
        w_exc_accept = 1'b0;
        w_drop_load  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_pcend = !i_flush;
                w_next  = ST_WAIT;
            end

            ST_WAIT: begin
                if (w_misaligned) begin
                    // Nothing goes to memory, so a flush here leaves nothing
                    // to drain and the state stays WAIT.
                    if (i_flush) begin
                        w_pcend = 1'b0;
                    end else if (w_slot_free) begin
                        w_exc_accept = 1'b1;
                        w_pcend      = 1'b0;
                    end
                end else begin
                    w_req = 1'b1;
                    if (i_flush) begin
                        w_pcend = 1'b0;
                        // Without an ack the request is still outstanding and
                        // its data must be swallowed before fetching the target.
                        if (!i_imem_ack) begin
                            w_drop_load = 1'b1;
                            w_next      = ST_DROP;
                        end
                    end else if (i_imem_ack && w_slot_free) begin
                        w_accept = 1'b1;
                        w_pcend  = 1'b0;
                    end
                end
            end

            ST_DROP: begin
                // Keep presenting the abandoned address until memory answers;
                // the answer closes the old transaction even if another flush
                // is seen in the same cycle.
                w_req   = 1'b1;
                w_addr  = r_drop_addr;
                w_pcend = !i_flush;
                if (i_imem_ack) begin
                    w_next = ST_WAIT;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and IF/ID register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_drop_addr <= '0;
            r_if_valid  <= 1'b0;
            r_if_instr  <= '0;
            r_if_pc     <= '0;
            r_if_pc4    <= '0;
            r_if_exc    <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            r_state <= w_next;

            if (w_drop_load) begin
                r_drop_addr <= w_addr;
            end

            if (i_flush) begin
                r_if_valid <= 1'b0;
            end else if (w_accept) begin
                r_if_valid  <= 1'b1;
                r_if_instr  <= i_imem_rdata;
                r_if_pc     <= w_addr;
                r_if_pc4    <= w_addr + ADDR_W'(4);
                r_if_exc    <= 1'b0;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end else if (w_exc_accept) begin
                r_if_valid  <= 1'b1;
                r_if_instr  <= '0;
                r_if_pc     <= i_pc;
                r_if_pc4    <= i_pc + ADDR_W'(4);
                r_if_exc    <= 1'b1;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end else if (!i_id_stall) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign o_pcend     = w_pcend;
    assign o_imem_req  = w_req;
    assign o_imem_addr = w_addr;
    assign o_if_valid  = r_if_valid;
    assign o_if_instr  = r_if_instr;
    assign o_if_pc     = r_if_pc;
    assign o_if_pc4    = r_if_pc4;
    assign o_if_exc    = r_if_exc;
    assign o_fetch_cnt = r_fetch_cnt;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch control stage sitting directly downstream of the program counter register. It issues the current `pc` to instruction memory over a req/ack handshake and captures the returned word into the IF/ID output register. It drives `pcend` back to the PC register so the PC advances only when the instruction at the current `pc` has been accepted. It also handles decode back-pressure and branch/exception flushes.

## Interface
- `ADDR_W`, 32, address and `pc` width.
- `DATA_W`, 32, instruction width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `pc` in ADDR_W: current PC from the PC register.
- `pcend` out 1: 1 = PC register holds, 0 = PC register loads `npc`.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_W: fetch address, word-aligned.
- `imem_ack` in 1: data valid. May arrive in the same cycle as `imem_req` (0-wait) or any later cycle.
- `imem_rdata` in DATA_W: fetched word, qualified by `imem_ack`.
- `id_stall` in 1: decode cannot take a new instruction.
- `flush` in 1: redirect. PC register loads the target via `npc` this cycle.
- `if_valid` out 1: IF/ID register holds a valid instruction.
- `if_instr` out DATA_W: instruction.
- `if_pc` out ADDR_W: address of `if_instr`.
- `if_pc4` out ADDR_W: `if_pc + 4`, mod 2^ADDR_W.
- `if_exc` out 1: fetch exception (see Configuration).
- `fetch_cnt` out 32: count of instructions accepted into IF/ID. Wraps at 2^32.

## Operation
- **States:** IDLE, WAIT, DROP.
- **Reset** (`reset`=0 at an edge):
  - State becomes IDLE.
  - `if_valid`, `if_instr`, `if_pc`, `if_pc4`, `if_exc` and `fetch_cnt` all reset to 0.
  - The internal `drop_addr` register resets to 0.
- **IDLE** lasts one cycle after reset release:
  - `imem_req`=0, `pcend`=1, then WAIT.
  - `flush` in IDLE drives `pcend`=0; next state is still WAIT.
- **WAIT**:
  - `imem_req`=1 and `imem_addr`={`pc`[ADDR_W-1:2],2'b00}, both combinational.
  - `pc` is held stable by `pcend`=1 until the fetch is accepted.
- **Slot free:** `slot_free` = !`if_valid` | !`id_stall`.
- **Accept** = WAIT & `imem_ack` & `slot_free` & !`flush`. On accept:
  - `pcend`=0.
  - At the edge: `if_valid`←1, `if_instr`←`imem_rdata`, `if_pc`←`imem_addr`, `if_pc4`←`imem_addr`+4, `fetch_cnt`++.
  - State stays WAIT, so the next cycle requests the new `pc` (back-to-back).
- **Ack while the slot is not free:** `pcend`=1 and the data is not captured. `imem_req` stays high; the memory re-presents the data on a later ack (memory is idempotent).
- **No accept and !`id_stall`:** `if_valid`←0.
- **`id_stall` with `if_valid`=1:** all IF/ID outputs hold.
- **Flush:**
  - `pcend`=0, and `if_valid`←0 regardless of `id_stall`.
  - If in WAIT without `imem_ack`: `drop_addr`←`imem_addr`, go to DROP.
  - If `imem_ack` arrives in the same cycle: data is discarded and state stays WAIT.
- **DROP:**
  - `imem_req`=1, `imem_addr`=`drop_addr`, `pcend`=1.
  - On `imem_ack` the data is discarded and state goes to WAIT.
  - A further `flush` in DROP drives `pcend`=0 and stays in DROP.
- **Reset asserted mid-request:** state goes to IDLE and the outstanding request is abandoned. The memory must tolerate a dropped `imem_req`.

## Timing
- `pcend`, `imem_req` and `imem_addr` are combinational from state, `pc`, `imem_ack`, `id_stall` and `flush`. All IF/ID outputs are registered.
- Latency from `imem_ack` (accepted) to `if_valid`=1 is 1 edge.
- Throughput is 1 instruction/cycle with a 0-wait memory and no stalls. An N-wait memory gives 1 per N+1 cycles.
- After reset release, the first `imem_req` occurs in cycle 2 (IDLE, then WAIT).
- After a flush, the first target fetch is requested the next cycle if no request was outstanding. Otherwise it follows the DROP ack.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - In WAIT with `pc`[1:0]≠0: `imem_req`=0.
  - When `slot_free` & !`flush`, this is treated as an immediate accept: `if_instr`←0 (nop), `if_exc`←1, `pcend`=0, and `fetch_cnt` increments.
  - `if_exc`←0 on every normal accept.
- `IFETCH_ALIGN_CHECK_EN` undefined:
  - `if_exc` is constant 0.
  - `pc`[1:0] is ignored (address forced to word alignment).

## Test plan
- **0-wait memory:** reset low 2 cycles, `pc` stepping 0x3000, 0x3004, 0x3008. Expect `imem_req` first in cycle 2, `if_pc`=0x3000, 0x3004, 0x3008 on consecutive cycles, and `fetch_cnt`=3.
- **2-wait memory at `pc`=0x3000:** expect `pcend`=1 for 2 cycles then 0 for 1 cycle, `if_valid` one cycle after the ack, and `if_pc4`=0x3004.
- **Decode stall:** `id_stall`=1 with `if_valid`=1 and an ack pending. Expect IF/ID to hold, `pcend`=1 and `imem_req`=1. Release the stall: the pending word is captured next edge.
- **Flush with outstanding request to 0x3010, no ack:** expect `pcend`=0 for 1 cycle, DROP with `imem_addr`=0x3010 until ack, ack data not captured, and `if_valid`=0. Then WAIT fetches the target address.
- **Flush with same-cycle ack:** expect data discarded, `if_valid`=0 and `fetch_cnt` unchanged.
- **With `IFETCH_ALIGN_CHECK_EN`, `pc`=0x3002:** expect `imem_req`=0, `if_exc`=1, `if_instr`=0 and `if_pc`=0x3002 after 1 edge.
